// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU control path.
// Opcode map, FSM state encoding and instruction field positions.
// Pure declarations: no latency, no flow control.
package cpu_pkg;

  // Instruction layout: [7:4] opcode, [3:0] immediate / jump target
  localparam int INSTR_W = 8;
  localparam int OPC_W   = 4;
  localparam int IMM_W   = 4;
  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 4;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;

  // ALU opcodes are passed straight through to the ALU
  localparam logic [OPC_W-1:0] OP_AND  = 4'h0;
  localparam logic [OPC_W-1:0] OP_OR   = 4'h1;
  localparam logic [OPC_W-1:0] OP_ADD  = 4'h2;
  localparam logic [OPC_W-1:0] OP_MUL  = 4'h3;
  localparam logic [OPC_W-1:0] OP_DIV  = 4'h4;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'h5;
  localparam logic [OPC_W-1:0] OP_NOR  = 4'h6;
  // Control opcodes handled entirely inside the controller
  localparam logic [OPC_W-1:0] OP_LDI  = 4'h7;
  localparam logic [OPC_W-1:0] OP_JMP  = 4'h8;
  localparam logic [OPC_W-1:0] OP_JZ   = 4'h9;
  localparam logic [OPC_W-1:0] OP_JC   = 4'hA;
  localparam logic [OPC_W-1:0] OP_OUT  = 4'hB;
  localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

  // Controller state encoding
  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_HALT      = 3'd4
  } state_t;

  // Field extraction helpers
  function automatic logic [OPC_W-1:0] instr_opcode(input logic [INSTR_W-1:0] ins);
    return ins[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [IMM_W-1:0] instr_imm(input logic [INSTR_W-1:0] ins);
    return ins[IMM_MSB:IMM_LSB];
  endfunction

endpackage

// File: rtl/cpu_instr_decoder.sv
// Instruction class decoder: opcode/immediate/flags -> one-hot-ish class bits.
// Latency: purely combinational, zero cycles.
// No flow control; outputs follow the held instruction register.
module cpu_instr_decoder
  import cpu_pkg::*;
(
  input  logic [OPC_W-1:0] i_opcode,
  input  logic [IMM_W-1:0] i_imm,
  input  logic             i_zero,
  input  logic             i_carry,
  output logic             o_is_alu,
  output logic             o_is_div_zero,
  output logic             o_is_ldi,
  output logic             o_is_jump,
  output logic             o_jump_taken,
  output logic             o_is_out,
  output logic             o_is_halt
);

  // Classify the instruction; divide-by-zero is pulled out of the ALU class
  // because the controller handles it without using the ALU result.
  always_comb begin
    o_is_alu      = 1'b0;
    o_is_div_zero = (i_opcode == OP_DIV) && (i_imm == '0);
    o_is_ldi      = 1'b0;
    o_is_jump     = 1'b0;
    o_jump_taken  = 1'b0;
    o_is_out      = 1'b0;
    o_is_halt     = 1'b0;
    case (i_opcode)
      OP_AND, OP_OR, OP_ADD, OP_MUL, OP_DIV, OP_SUB, OP_NOR: begin
        o_is_alu = !o_is_div_zero;
      end
      OP_LDI: o_is_ldi = 1'b1;
      OP_JMP: begin
        o_is_jump    = 1'b1;
        o_jump_taken = 1'b1;
      end
      OP_JZ: begin
        o_is_jump    = 1'b1;
        o_jump_taken = i_zero;
      end
      OP_JC: begin
        o_is_jump    = 1'b1;
        o_jump_taken = i_carry;
      end
      OP_OUT:  o_is_out  = 1'b1;
      OP_HALT: o_is_halt = 1'b1;
      default: ; // 0xC-0xE are NOPs
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Fetch/decode/execute controller driving the ALU and owning acc/flags/pc.
// Latency: ALU ops 4 cycles FETCH->FETCH, all other ops (and div-by-zero) 3 cycles.
// Backpressure: run=0 holds the FSM in FETCH; an instruction already started completes.
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH   = 4,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  run,
  output logic [PC_WIDTH-1:0]   pcAddr,
  input  logic [INSTR_W-1:0]    instr,
  output logic [DATA_WIDTH-1:0] aluA,
  output logic [DATA_WIDTH-1:0] aluB,
  output logic [OPC_W-1:0]      aluOpcode,
  input  logic [DATA_WIDTH-1:0] aluResult,
  input  logic                  aluZero,
  input  logic                  aluCarry,
  output logic [DATA_WIDTH-1:0] acc,
  output logic                  zeroFlag,
  output logic                  carryFlag,
  output logic [DATA_WIDTH-1:0] outData,
  output logic                  outValid,
  output logic                  halted
);

  state_t                r_state;
  logic [PC_WIDTH-1:0]   r_pc;
  logic [INSTR_W-1:0]    r_ir;
  logic [DATA_WIDTH-1:0] r_acc;
  logic                  r_zero;
  logic                  r_carry;
  logic [DATA_WIDTH-1:0] r_alu_a;
  logic [DATA_WIDTH-1:0] r_alu_b;
  logic [OPC_W-1:0]      r_alu_op;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_vld;
  logic                  r_halted;

  logic [OPC_W-1:0]      w_opcode;
  logic [IMM_W-1:0]      w_imm;
  logic [DATA_WIDTH-1:0] w_imm_data;
  logic [PC_WIDTH-1:0]   w_jump_target;
  logic                  w_is_alu;
  logic                  w_is_div_zero;
  logic                  w_is_ldi;
  logic                  w_is_jump;
  logic                  w_jump_taken;
  logic                  w_is_out;
  logic                  w_is_halt;

  // Immediate is zero-extended or truncated to the datapath / pc width
  assign w_opcode      = instr_opcode(r_ir);
  assign w_imm         = instr_imm(r_ir);
  assign w_imm_data    = DATA_WIDTH'(w_imm);
  assign w_jump_target = PC_WIDTH'(w_imm);

  cpu_instr_decoder u_decoder (
    .i_opcode      (w_opcode),
    .i_imm         (w_imm),
    .i_zero        (r_zero),
    .i_carry       (r_carry),
    .o_is_alu      (w_is_alu),
    .o_is_div_zero (w_is_div_zero),
    .o_is_ldi      (w_is_ldi),
    .o_is_jump     (w_is_jump),
    .o_jump_taken  (w_jump_taken),
    .o_is_out      (w_is_out),
    .o_is_halt     (w_is_halt)
  );

  // Controller FSM plus every architectural register; outputs are all registered
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_FETCH;
      r_pc       <= '0;
      r_ir       <= '0;
      r_acc      <= '0;
      r_zero     <= 1'b0;
      r_carry    <= 1'b0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_op   <= '0;
      r_out_data <= '0;
      r_out_vld  <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      // outValid is a single-cycle pulse; only EXECUTE of OUT re-arms it
      r_out_vld <= 1'b0;
      case (r_state)
        ST_FETCH: begin
          // ROM address is pc; data arrives while we sit in DECODE
          if (run) begin
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          r_ir    <= instr;
          r_pc    <= r_pc + PC_WIDTH'(1);
          r_state <= ST_EXECUTE;
        end
        ST_EXECUTE: begin
          r_state <= ST_FETCH;
          if (w_is_div_zero) begin
            // Saturate and flag overflow without touching the ALU operands
            r_acc   <= '1;
            r_carry <= 1'b1;
            r_zero  <= 1'b0;
          end else if (w_is_alu) begin
            r_alu_a  <= r_acc;
            r_alu_b  <= w_imm_data;
            r_alu_op <= w_opcode;
            r_state  <= ST_WRITEBACK;
          end else if (w_is_ldi) begin
            r_acc <= w_imm_data;
          end else if (w_is_jump) begin
            if (w_jump_taken) begin
              r_pc <= w_jump_target;
            end
          end else if (w_is_out) begin
            r_out_data <= r_acc;
            r_out_vld  <= 1'b1;
          end else if (w_is_halt) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end
        end
        ST_WRITEBACK: begin
          // ALU operands have been stable for a full cycle by now
          r_acc   <= aluResult;
          r_zero  <= aluZero;
          r_carry <= aluCarry;
          r_state <= ST_FETCH;
        end
        ST_HALT: begin
          // Only reset leaves HALT; run is deliberately ignored
          r_halted <= 1'b1;
        end
        default: begin
          r_state <= ST_FETCH;
        end
      endcase
    end
  end

  assign pcAddr    = r_pc;
  assign aluA      = r_alu_a;
  assign aluB      = r_alu_b;
  assign aluOpcode = r_alu_op;
  assign acc       = r_acc;
  assign zeroFlag  = r_zero;
  assign carryFlag = r_carry;
  assign outData   = r_out_data;
  assign outValid  = r_out_vld;
  assign halted    = r_halted;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Scoreboard bench for cpu_control_unit with an ISA-level reference model.
// Expected OUT/HALT events are queued when a program is loaded; a monitor pops them.
module tb_cpu_control_unit;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       run = 1'b0;
  logic [3:0] pcAddr;
  logic [7:0] instr = 8'h00;
  logic [3:0] aluA, aluB, aluOpcode, aluResult;
  logic       aluZero, aluCarry;
  logic [3:0] acc, outData;
  logic       zeroFlag, carryFlag, outValid, halted;

  always #5 clock = ~clock;

  cpu_control_unit #(.PC_WIDTH(4), .DATA_WIDTH(4)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .run       (run),
    .pcAddr    (pcAddr),
    .instr     (instr),
    .aluA      (aluA),
    .aluB      (aluB),
    .aluOpcode (aluOpcode),
    .aluResult (aluResult),
    .aluZero   (aluZero),
    .aluCarry  (aluCarry),
    .acc       (acc),
    .zeroFlag  (zeroFlag),
    .carryFlag (carryFlag),
    .outData   (outData),
    .outValid  (outValid),
    .halted    (halted)
  );

  // Synchronous program ROM
  logic [7:0] rom [16];
  always @(posedge clock) instr <= rom[pcAddr];

  // 4-bit ALU semantics: returns {zero, carry, result}
  function automatic logic [5:0] alu_ref(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    int ia, ib, w;
    logic [3:0] r;
    logic c;
    ia = int'(a);
    ib = int'(b);
    c = 1'b0;
    r = 4'h0;
    case (op)
      4'h0: r = a & b;
      4'h1: r = a | b;
      4'h2: begin w = ia + ib; r = 4'(w % 16); c = (w > 15); end
      4'h3: begin w = ia * ib; r = 4'(w % 16); c = (w > 15); end
      4'h4: begin if (ib == 0) begin r = 4'hF; c = 1'b1; end else r = 4'(ia / ib); end
      4'h5: begin w = ia - ib; r = 4'((w + 16) % 16); c = (ia < ib); end
      4'h6: r = ~(a | b);
      default: r = 4'h0;
    endcase
    return {(r == 4'h0), c, r};
  endfunction

  assign {aluZero, aluCarry, aluResult} = alu_ref(aluOpcode, aluA, aluB);

  typedef struct {
    bit         is_halt;
    int         stamp;
    logic [3:0] acc, pc, aop, aa, ab;
    logic       z, c;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc;
  int  m_stall_start, m_halt_pc;
  logic [3:0] m_stall_pc, m_stall_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Cycle index since reset release; sampled at negedge it names the current cycle
  always @(posedge clock or negedge reset_n)
    if (!reset_n) cyc <= 0; else cyc <= cyc + 1;

  // Monitor: pop the next expected event whenever the DUT presents one
  logic prev_halted = 1'b0;
  always @(negedge clock) begin
    ev_t e;
    if (reset_n) begin
      if (outValid) begin
        if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("ev_is_out", 32'(e.is_halt), 0);
          chk("out_time", cyc, e.stamp);
          chk("outData", outData, e.acc);
          chk("out_zero", zeroFlag, e.z);
          chk("out_carry", carryFlag, e.c);
          chk("out_pc", pcAddr, e.pc);
        end
      end
      if (halted && !prev_halted) begin
        if (exp_q.size() == 0) chk("unexpected_halt", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("ev_is_halt", 32'(e.is_halt), 1);
          chk("halt_time", cyc, e.stamp);
          chk("halt_acc", acc, e.acc);
          chk("halt_zero", zeroFlag, e.z);
          chk("halt_carry", carryFlag, e.c);
          chk("halt_pc", pcAddr, e.pc);
          chk("halt_aluOpcode", aluOpcode, e.aop);
          chk("halt_aluA", aluA, e.aa);
          chk("halt_aluB", aluB, e.ab);
        end
      end
      prev_halted <= halted;
    end else begin
      prev_halted <= 1'b0;
    end
  end

  // Architectural model: executes the ROM program instruction by instruction,
  // adding 4 cycles per ALU op and 3 per anything else, queuing OUT/HALT events.
  task automatic model(input int stall_idx, input int stall_len);
    logic [3:0] pc, a, aop, aa, ab, op, imm;
    logic z, c;
    int t;
    ev_t e;
    pc = 0; a = 0; aop = 0; aa = 0; ab = 0; z = 0; c = 0; t = 0;
    m_stall_start = -1;
    m_halt_pc = -1;
    for (int step = 0; step < 64; step++) begin
      if (step == stall_idx) begin
        m_stall_start = t; m_stall_pc = pc; m_stall_acc = a; t += stall_len;
      end
      op = rom[pc][7:4];
      imm = rom[pc][3:0];
      pc = pc + 4'd1;
      if (op <= 4'h6) begin
        if (op == 4'h4 && imm == 4'h0) begin
          a = 4'hF; c = 1'b1; z = 1'b0; t += 3;
        end else begin
          aop = op; aa = a; ab = imm;
          {z, c, a} = alu_ref(op, a, imm);
          t += 4;
        end
      end else begin
        t += 3;
        e.stamp = t; e.acc = a; e.aop = aop; e.aa = aa; e.ab = ab;
        case (op)
          4'h7: a = imm;
          4'h8: pc = imm;
          4'h9: if (z) pc = imm;
          4'hA: if (c) pc = imm;
          4'hB: begin
            e.is_halt = 1'b0; e.pc = pc; e.z = z; e.c = c; exp_q.push_back(e);
          end
          4'hF: begin
            e.is_halt = 1'b1; e.pc = pc; e.z = z; e.c = c; exp_q.push_back(e);
            m_halt_pc = int'(pc);
            return;
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_pcAddr"}, pcAddr, 0);
    chk({tag, "_acc"}, acc, 0);
    chk({tag, "_zero"}, zeroFlag, 0);
    chk({tag, "_carry"}, carryFlag, 0);
    chk({tag, "_aluA"}, aluA, 0);
    chk({tag, "_aluB"}, aluB, 0);
    chk({tag, "_aluOpcode"}, aluOpcode, 0);
    chk({tag, "_outData"}, outData, 0);
    chk({tag, "_outValid"}, outValid, 0);
    chk({tag, "_halted"}, halted, 0);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'hF0;
  endtask

  // Reset, model the loaded program, run it with optional 5-cycle stall, drain events
  task automatic run_prog(input string name, input int stall_idx, input bit halt_toggle);
    reset_n = 1'b0;
    run = 1'b0;
    exp_q.delete();
    @(negedge clock);
    model(stall_idx, 5);
    reset_n = 1'b1;
    run = 1'b1;
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
      @(negedge clock);
      if (cyc == m_stall_start) begin
        run = 1'b0;
        repeat (5) begin
          @(negedge clock);
          chk({name, "_stall_pc"}, pcAddr, m_stall_pc);
          chk({name, "_stall_acc"}, acc, m_stall_acc);
          chk({name, "_stall_outValid"}, outValid, 0);
        end
        run = 1'b1;
      end
    end
    chk({name, "_drain"}, exp_q.size(), 0);
    if (halt_toggle) begin
      repeat (10) begin
        run = 1'($urandom_range(0, 1));
        @(negedge clock);
        chk({name, "_halt_hold"}, halted, 1);
        chk({name, "_halt_pc_hold"}, pcAddr, m_halt_pc);
      end
    end
  endtask

  initial begin
    logic [3:0] op, imm;
    clear_rom();
    repeat (2) @(negedge clock);
    check_all_zero("reset");

    // LDI 3; ADD 5; OUT; HALT
    clear_rom();
    rom[0] = 8'h73; rom[1] = 8'h25; rom[2] = 8'hB0;
    run_prog("ldi_add", -1, 1'b0);

    // LDI 9; ADD 9 (carry); JC 6 taken
    clear_rom();
    rom[0] = 8'h79; rom[1] = 8'h29; rom[2] = 8'hA6; rom[6] = 8'hB0;
    run_prog("jc_taken", -1, 1'b0);

    // Carry clear: JC falls through
    clear_rom();
    rom[0] = 8'h71; rom[1] = 8'h22; rom[2] = 8'hA6; rom[3] = 8'hB0; rom[6] = 8'hB0;
    run_prog("jc_fall", -1, 1'b0);

    // LDI 5; SUB 5; JZ 0xA
    clear_rom();
    rom[0] = 8'h75; rom[1] = 8'h55; rom[2] = 8'h9A; rom[3] = 8'hB0; rom[10] = 8'hB0;
    run_prog("jz_taken", -1, 1'b0);

    // Divide by zero must leave the ALU operand registers from the earlier ADD
    clear_rom();
    rom[0] = 8'h72; rom[1] = 8'h21; rom[2] = 8'h77; rom[3] = 8'h40; rom[4] = 8'hB0;
    run_prog("div_zero", -1, 1'b0);

    // LDI 0xC; OUT with 5-cycle stall in front of OUT
    clear_rom();
    rom[0] = 8'h7C; rom[1] = 8'hB0; rom[2] = 8'h73; rom[3] = 8'hB0;
    run_prog("stall_out", 1, 1'b0);

    // JMP 0xF at 0xE, NOP at 0xF wraps to 0; then HALT with run toggling
    clear_rom();
    rom[0] = 8'hA5; rom[1] = 8'h79; rom[2] = 8'h29; rom[3] = 8'h8E;
    rom[5] = 8'hB0; rom[14] = 8'h8F; rom[15] = 8'hC0;
    run_prog("pc_wrap", -1, 1'b1);

    // Reset in the WRITEBACK cycle of ADD
    clear_rom();
    rom[0] = 8'h73; rom[1] = 8'h25;
    exp_q.delete();
    reset_n = 1'b0;
    run = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    run = 1'b1;
    repeat (6) @(negedge clock);
    chk("wb_aluOpcode", aluOpcode, 2);
    chk("wb_aluA", aluA, 3);
    chk("wb_aluB", aluB, 5);
    reset_n = 1'b0;
    #1;
    check_all_zero("midwb_reset");
    @(negedge clock);
    check_all_zero("midwb_after_edge");

    // Random forward-jump programs that always terminate at HALT in 0xF
    for (int p = 0; p < 24; p++) begin
      for (int a = 0; a < 15; a++) begin
        op = 4'($urandom_range(0, 15));
        imm = 4'($urandom_range(0, 15));
        if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'hB;
        if ($urandom_range(0, 4) == 0) op = 4'hB;
        if (op == 4'h8 || op == 4'h9 || op == 4'hA) imm = 4'($urandom_range(a + 1, 15));
        if (op == 4'h4 && $urandom_range(0, 2) == 0) imm = 4'h0;
        rom[a] = {op, imm};
      end
      rom[15] = 8'hF0;
      run_prog("random", (p % 2 == 1) ? int'($urandom_range(1, 4)) : -1, (p % 6 == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
